// File: rtl/dct_link_pkg.sv
// Shared definitions for the dct -> idct coupler.
//   BLK_DEF / BLK_LOG2 : default block size (coefficients per 8x8 block) and its log2
//   rd_state_e         : read-side FSM encoding
//   sat_signed()       : clamp a signed value into a w-bit two's-complement range
package dct_link_pkg;

    localparam int unsigned BLK_DEF  = 64;
    localparam int unsigned BLK_LOG2 = $clog2(BLK_DEF);

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ARM   = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_e;

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/link_requant.sv
// Combinational requantizer for the dct -> idct coupler.
// Optional feature macro: LINK_ROUND_EN (round-half-up with saturation instead of truncation).
// Ports:
//   up_dout_i  in  IN_W    signed dct coefficient
//   coef_o     out COEF_W  requantized coefficient (stored in the ping-pong buffer)
//   rd_coef_i  in  COEF_W  stored coefficient being prefetched for the idct
//   ext_o      out OUT_W   rd_coef_i sign-extended to the idct word width
module link_requant
    import dct_link_pkg::*;
#(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned SHIFT = 18,
    parameter int unsigned OUT_W = 32,
    localparam int unsigned COEF_W = IN_W - SHIFT
) (
    input  logic [IN_W-1:0]   up_dout_i,
    output logic [COEF_W-1:0] coef_o,
    input  logic [COEF_W-1:0] rd_coef_i,
    output logic [OUT_W-1:0]  ext_o
);

`ifdef LINK_ROUND_EN
    localparam logic [IN_W:0] HALF = (IN_W + 1)'(1) << (SHIFT - 1);

    logic signed [IN_W:0]   sum;
    logic signed [COEF_W:0] shifted;

    // One extra bit keeps the rounding add from wrapping; only the positive
    // end can then exceed the COEF_W range, and sat_signed clamps it.
    always_comb begin
        sum     = $signed({up_dout_i[IN_W-1], up_dout_i}) + $signed(HALF);
        shifted = (COEF_W + 1)'(sum >>> SHIFT);
        coef_o  = COEF_W'(sat_signed(64'(shifted), COEF_W));
    end
`else
    logic unused_lsbs;

    // Truncating arithmetic shift is just the upper bit field.
    always_comb begin
        coef_o      = up_dout_i[IN_W-1:SHIFT];
        unused_lsbs = ^up_dout_i[SHIFT-1:0];
    end
`endif

    always_comb begin
        ext_o = {{(OUT_W - COEF_W){rd_coef_i[COEF_W-1]}}, rd_coef_i};
    end

endmodule

// File: rtl/dct_idct_link.sv
// Coupler between the dct and idct cores: requantizes each dct coefficient,
// buffers 8x8 blocks in a two-bank ping-pong store and hands full blocks to
// the idct with a start/reading handshake.
// Optional feature macro: LINK_ROUND_EN (selected inside link_requant).
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high
//   up_done    in   1      one coefficient on up_dout per high cycle
//   up_dout    in   IN_W   dct coefficient, signed
//   dn_start   out  1      a full bank is waiting for / being read by the idct
//   dn_reading in   1      head coefficient consumed on each edge with dn_start&dn_reading
//   dn_din     out  OUT_W  registered head coefficient of the bank being read
//   ovf        out  1      sticky: a coefficient was dropped, both banks full
//   blk_cnt    out  16     blocks fully delivered, wraps
module dct_idct_link
    import dct_link_pkg::*;
#(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned SHIFT = 18,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned BLK   = BLK_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up_done,
    input  logic [IN_W-1:0]  up_dout,
    output logic             dn_start,
    input  logic             dn_reading,
    output logic [OUT_W-1:0] dn_din,
    output logic             ovf,
    output logic [15:0]      blk_cnt
);

    localparam int unsigned COEF_W = IN_W - SHIFT;
    localparam int unsigned PTR_W  = $clog2(BLK);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(BLK - 1);

    logic [COEF_W-1:0] mem_q [2*BLK];

    logic             wr_bank_q, wr_bank_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]       full_q, full_d;
    logic             ovf_q, ovf_d;

    rd_state_e        state_q, state_d;
    logic             rd_bank_q, rd_bank_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic             dn_start_q, dn_start_d;
    logic [OUT_W-1:0] dn_din_q, dn_din_d;
    logic [15:0]      blk_cnt_q, blk_cnt_d;

    logic             wr_en, set_full, clr_full;
    logic             pf_load, pf_clear;
    logic [PTR_W:0]   pf_addr;
    logic [COEF_W-1:0] wr_coef;
    logic [OUT_W-1:0] pf_ext;

    link_requant #(
        .IN_W (IN_W),
        .SHIFT(SHIFT),
        .OUT_W(OUT_W)
    ) u_requant (
        .up_dout_i(up_dout),
        .coef_o   (wr_coef),
        .rd_coef_i(mem_q[pf_addr]),
        .ext_o    (pf_ext)
    );

    assign rd_ptr_nx = rd_ptr_q + 1'b1;

    always_comb begin
        wr_bank_d  = wr_bank_q;
        wr_ptr_d   = wr_ptr_q;
        ovf_d      = ovf_q;
        wr_en      = 1'b0;
        set_full   = 1'b0;
        clr_full   = 1'b0;
        state_d    = state_q;
        rd_bank_d  = rd_bank_q;
        rd_ptr_d   = rd_ptr_q;
        dn_start_d = dn_start_q;
        blk_cnt_d  = blk_cnt_q;
        pf_load    = 1'b0;
        pf_clear   = 1'b0;
        pf_addr    = {rd_bank_q, rd_ptr_q};

        // write side
        if (up_done) begin
            if (full_q[wr_bank_q]) begin
                ovf_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (wr_ptr_q == LAST) begin
                    set_full  = 1'b1;
                    wr_bank_d = ~wr_bank_q;
                    wr_ptr_d  = '0;
                end else begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end
        end

        // read side: every transition into a readable state prefetches the
        // next head word so dn_din is valid whenever dn_start is high
        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d    = RD_ARM;
                    dn_start_d = 1'b1;
                    pf_load    = 1'b1;
                    pf_addr    = {rd_bank_q, {PTR_W{1'b0}}};
                end
            end
            RD_ARM, RD_DRAIN: begin
                if (dn_reading) begin
                    if (rd_ptr_q == LAST) begin
                        clr_full  = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        rd_ptr_d  = '0;
                        blk_cnt_d = blk_cnt_q + 16'd1;
                        if (full_q[~rd_bank_q]) begin
                            state_d = RD_ARM;
                            pf_load = 1'b1;
                            pf_addr = {~rd_bank_q, {PTR_W{1'b0}}};
                        end else begin
                            state_d    = RD_IDLE;
                            dn_start_d = 1'b0;
                            pf_clear   = 1'b1;
                        end
                    end else begin
                        state_d  = RD_DRAIN;
                        rd_ptr_d = rd_ptr_nx;
                        pf_load  = 1'b1;
                        pf_addr  = {rd_bank_q, rd_ptr_nx};
                    end
                end
            end
            default: begin
                state_d    = RD_IDLE;
                dn_start_d = 1'b0;
                pf_clear   = 1'b1;
            end
        endcase

        // set and clear always target different banks, so both apply
        full_d = full_q;
        if (clr_full)
            full_d[rd_bank_q] = 1'b0;
        if (set_full)
            full_d[wr_bank_q] = 1'b1;
    end

    always_comb begin
        dn_din_d = dn_din_q;
        if (pf_load)
            dn_din_d = pf_ext;
        else if (pf_clear)
            dn_din_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank_q  <= 1'b0;
            wr_ptr_q   <= '0;
            full_q     <= '0;
            ovf_q      <= 1'b0;
            state_q    <= RD_IDLE;
            rd_bank_q  <= 1'b0;
            rd_ptr_q   <= '0;
            dn_start_q <= 1'b0;
            dn_din_q   <= '0;
            blk_cnt_q  <= '0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            wr_ptr_q   <= wr_ptr_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            rd_bank_q  <= rd_bank_d;
            rd_ptr_q   <= rd_ptr_d;
            dn_start_q <= dn_start_d;
            dn_din_q   <= dn_din_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[{wr_bank_q, wr_ptr_q}] <= wr_coef;
    end

    assign dn_start = dn_start_q;
    assign dn_din   = dn_din_q;
    assign ovf      = ovf_q;
    assign blk_cnt  = blk_cnt_q;

endmodule

// File: tb/tb_dct_idct_link.sv
module tb_dct_idct_link;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        up_done = 1'b0;
    logic [31:0] up_dout = '0;
    logic        dn_start;
    logic        dn_reading = 1'b0;
    logic [31:0] dn_din;
    logic        ovf;
    logic [15:0] blk_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    dct_idct_link #(
        .IN_W (32),
        .SHIFT(18),
        .OUT_W(32),
        .BLK  (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .up_done   (up_done),
        .up_dout   (up_dout),
        .dn_start  (dn_start),
        .dn_reading(dn_reading),
        .dn_din    (dn_din),
        .ovf       (ovf),
        .blk_cnt   (blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: a word is consumed on the next rising edge when start&reading.
    always @(negedge clk) begin
        if (!reset && dn_start && dn_reading) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got %h, expected no word", dn_din);
            end else begin
                chk("dn_din", dn_din, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] v);
        up_done = 1'b1;
        up_dout = v;
        tick();
        up_done = 1'b0;
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_blk(input logic [15:0] target, input int budget);
        int n;
        n = 0;
        while (blk_cnt !== target && n < budget) begin
            tick();
            n++;
        end
        chk("blk_cnt_wait", {16'd0, blk_cnt}, {16'd0, target});
    endtask

    logic [31:0] v2_in  [8];
    logic [31:0] v2_exp [8];
    int drops;

    initial begin
        v2_in = '{32'hFFFC0000, 32'h00020000, 32'h7FFFFFFF, 32'h80000000,
                  32'h0003FFFF, 32'hFFFDFFFF, 32'hFFFE0000, 32'h00040000};
`ifdef LINK_ROUND_EN
        v2_exp = '{32'hFFFFFFFF, 32'h00000001, 32'h00001FFF, 32'hFFFFE000,
                   32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
`else
        v2_exp = '{32'hFFFFFFFF, 32'h00000000, 32'h00001FFF, 32'hFFFFE000,
                   32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
`endif

        // reset state
        #1;
        chk("rst_dn_start", {31'd0, dn_start}, 32'd0);
        chk("rst_dn_din", dn_din, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_blk_cnt", {16'd0, blk_cnt}, 32'd0);
        tick();
        reset = 1'b0;

        // 1: constant block, start latency, one delivered block
        dn_reading = 1'b1;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(32'h00000001);
            put(32'h00040000);
        end
        chk("lat_start_edge1", {31'd0, dn_start}, 32'd0);
        tick();
        chk("lat_start_edge2", {31'd0, dn_start}, 32'd1);
        wait_blk(16'd1, 200);
        chk("t1_start_low", {31'd0, dn_start}, 32'd0);
        chk("t1_q_empty", exp_q.size(), 32'd0);

        // 2: requant corner values
        for (int i = 0; i < 64; i++) begin
            if (i < 8) begin
                exp_q.push_back(v2_exp[i]);
                put(v2_in[i]);
            end else begin
                exp_q.push_back(32'h00000000);
                put(32'h00000000);
            end
        end
        wait_blk(16'd2, 200);
        chk("t2_q_empty", exp_q.size(), 32'd0);

        // 4: three blocks with the reader stalled; third block is dropped
        sync_reset();
        dn_reading = 1'b0;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(32'(i));
            put(32'(i) << 18);
        end
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(32'(i + 100));
            put(32'(i + 100) << 18);
        end
        chk("t4_ovf_before", {31'd0, ovf}, 32'd0);
        put(32'h00400000);
        chk("t4_ovf_set", {31'd0, ovf}, 32'd1);
        for (int i = 1; i < 64; i++)
            put(32'h00400000);
        chk("t4_start_wait", {31'd0, dn_start}, 32'd1);
        chk("t4_head", dn_din, 32'd0);
        chk("t4_blk_cnt0", {16'd0, blk_cnt}, 32'd0);
        dn_reading = 1'b1;
        drops = 0;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (blk_cnt == 16'd2)
                break;
            if (!dn_start)
                drops++;
        end
        chk("t4_start_drops", drops, 32'd0);
        chk("t4_blk_cnt", {16'd0, blk_cnt}, 32'd2);
        chk("t4_start_low", {31'd0, dn_start}, 32'd0);
        chk("t4_ovf_sticky", {31'd0, ovf}, 32'd1);
        chk("t4_q_empty", exp_q.size(), 32'd0);

        // 5: toggling reader sees each entry once, in order
        sync_reset();
        dn_reading = 1'b0;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(32'(i + 1000));
            put(32'(i + 1000) << 18);
        end
        for (int n = 0; n < 400 && blk_cnt != 16'd1; n++) begin
            dn_reading = ~dn_reading;
            tick();
        end
        chk("t5_blk_cnt", {16'd0, blk_cnt}, 32'd1);
        chk("t5_q_empty", exp_q.size(), 32'd0);

        // 6: async reset mid-cycle with a waiting block and a partial block
        dn_reading = 1'b0;
        for (int i = 0; i < 64; i++)
            put(32'h00140000);
        for (int i = 0; i < 30; i++)
            put(32'h00080000);
        chk("t6_start_pre", {31'd0, dn_start}, 32'd1);
        chk("t6_head_pre", dn_din, 32'h00000005);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_start", {31'd0, dn_start}, 32'd0);
        chk("t6_rst_din", dn_din, 32'd0);
        chk("t6_rst_blk_cnt", {16'd0, blk_cnt}, 32'd0);
        chk("t6_rst_ovf", {31'd0, ovf}, 32'd0);
        tick();
        reset = 1'b0;
        dn_reading = 1'b1;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(32'(i + 7));
            put(32'(i + 7) << 18);
        end
        wait_blk(16'd1, 200);
        chk("t6_q_empty", exp_q.size(), 32'd0);
        chk("t6_ovf", {31'd0, ovf}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
